// File: rtl/vram_port_arbiter_if.sv
// Bundles every request, response and RAM port-B signal of the VRAM arbiter.
// Latency: none, wires only.
// Backpressure: writers are held off by wr_ready; display and clear have no backpressure.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic                  disp_req;
    logic [ADDR_W-1:0]     disp_addr;
    logic [DATA_W-1:0]     disp_rdata;
    logic                  disp_rvalid;
    logic [1:0]            wr_valid;
    logic [2*ADDR_W-1:0]   wr_addr;
    logic [2*DATA_W-1:0]   wr_data;
    logic [7:0]            wr_be;
    logic [1:0]            wr_ready;
    logic                  clr_start;
    logic                  clr_busy;
    logic                  clr_done;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_data;
    logic [3:0]            ram_be;
    logic                  ram_wren;
    logic                  ram_rden;
    logic [DATA_W-1:0]     ram_q;
    logic                  disp_miss;
    logic                  miss_clr;

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, wr_be,
               clr_start, ram_q, miss_clr,
        output disp_rdata, disp_rvalid, wr_ready, clr_busy, clr_done,
               ram_addr, ram_data, ram_be, ram_wren, ram_rden, disp_miss
    );

    // Requester / RAM side
    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, wr_be,
               clr_start, ram_q, miss_clr,
        input  disp_rdata, disp_rvalid, wr_ready, clr_busy, clr_done,
               ram_addr, ram_data, ram_be, ram_wren, ram_rden, disp_miss
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Arbitrates VRAM port B between display fetch, two writers and a clear sweep.
// Latency: grant to ram_* is 1 cycle; display read data returns 2 cycles after grant.
// Backpressure: writers wait on wr_ready; a starved writer is forced through by dropping one display fetch.
module vram_port_arbiter #(
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 32,
    parameter int                MAX_STALL  = 4,
    parameter int                CLEAR_LAST = 599,
    parameter logic [DATA_W-1:0] CLEAR_WORD = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    vram_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_t;

    clr_state_t          state_q;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic                clr_busy_q;
    logic                clr_done_q;
    logic [2:0]          stall_q, stall_d;
    logic                rr_q, rr_d;        // writer favoured when both are valid
    logic                miss_q, miss_d;
    logic [1:0]          rv_q;              // display read-valid pipe
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;
    logic [3:0]          ram_be_q;
    logic                ram_wren_q;
    logic                ram_rden_q;

    logic                any_wr, stall_cond, forced;
    logic                gnt_disp, gnt_wr, gnt_clr, wr_sel;
    logic [1:0]          wr_ready_c;

    // Single grant per cycle: display, forced writer, round-robin writer, clear, idle
    always_comb begin
        any_wr     = |bus.wr_valid;
        stall_cond = bus.disp_req & any_wr;
        forced     = stall_cond & (stall_q == 3'(MAX_STALL));
        gnt_disp   = bus.disp_req & ~forced;
        gnt_wr     = ~gnt_disp & any_wr;
        gnt_clr    = ~gnt_disp & ~any_wr & (state_q == ST_CLEAR);
        wr_sel     = (&bus.wr_valid) ? rr_q : bus.wr_valid[1];
        wr_ready_c = 2'b00;
        if (gnt_wr && RESET) begin
            wr_ready_c[wr_sel] = 1'b1;
        end
        stall_d = (gnt_wr || !stall_cond) ? 3'd0 : stall_q + 3'd1;
        rr_d    = gnt_wr ? ~wr_sel : rr_q;
        // a forced drop in the same cycle as a clear request keeps the flag set
        miss_d  = forced ? 1'b1 : (bus.miss_clr ? 1'b0 : miss_q);
    end

    // Register the winning request onto RAM port B and track stall/fairness state
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_be_q   <= '0;
            ram_wren_q <= 1'b0;
            ram_rden_q <= 1'b0;
            rv_q       <= 2'b00;
            stall_q    <= 3'd0;
            rr_q       <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            ram_wren_q <= gnt_wr | gnt_clr;
            ram_rden_q <= gnt_disp;
            if (gnt_disp) begin
                ram_addr_q <= bus.disp_addr;
                ram_be_q   <= 4'hF;
            end else if (gnt_wr) begin
                ram_addr_q <= wr_sel ? bus.wr_addr[2*ADDR_W-1:ADDR_W] : bus.wr_addr[ADDR_W-1:0];
                ram_data_q <= wr_sel ? bus.wr_data[2*DATA_W-1:DATA_W] : bus.wr_data[DATA_W-1:0];
                ram_be_q   <= wr_sel ? bus.wr_be[7:4] : bus.wr_be[3:0];
            end else if (gnt_clr) begin
                ram_addr_q <= clr_addr_q;
                ram_data_q <= CLEAR_WORD;
                ram_be_q   <= 4'hF;
            end
            rv_q    <= {rv_q[0], gnt_disp};
            stall_q <= stall_d;
            rr_q    <= rr_d;
            miss_q  <= miss_d;
        end
    end

    // Clear sweep FSM; the address only advances on cycles the sweep actually wins
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (bus.clr_start) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (gnt_clr) begin
                        if (clr_addr_q == ADDR_W'(CLEAR_LAST)) begin
                            state_q    <= ST_DONE;
                            clr_busy_q <= 1'b0;
                            clr_done_q <= 1'b1;
                        end else begin
                            clr_addr_q <= clr_addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready    = wr_ready_c;
    assign bus.disp_rdata  = bus.ram_q;
    assign bus.disp_rvalid = rv_q[1];
    assign bus.disp_miss   = miss_q;
    assign bus.clr_busy    = clr_busy_q;
    assign bus.clr_done    = clr_done_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.ram_be      = ram_be_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_rden    = ram_rden_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboarded bench for vram_port_arbiter with a registered RAM model on port B.
// Latency: expected port-B ops are checked one cycle after grant, read data two cycles after.
// Backpressure: writer readiness is predicted by a per-cycle reference model.
module tb_vram_port_arbiter;
    localparam int AW         = 11;
    localparam int DW         = 32;
    localparam int MAX_STALL  = 4;
    localparam int CLEAR_LAST = 599;

    typedef struct {
        int          cyc;
        int          kind;      // 0 idle, 1 read, 2 write
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } op_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #10 CLK = ~CLK;

    vram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_STALL(MAX_STALL),
        .CLEAR_LAST(CLEAR_LAST), .CLEAR_WORD(32'h0000_0000)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_wren = 0, n_done = 0, n_rdy0 = 0, n_rdy1 = 0;
    bit armed  = 1'b0;

    // reference model state
    op_t         exq[$];
    int          m_stall, m_last, m_phase, m_caddr;
    bit          m_miss;
    logic [31:0] m_mem [0:2047];

    function automatic logic [31:0] init_pat(input logic [10:0] a);
        return {5'h15, a, 5'h0A, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc++;

    // registered RAM, 1-cycle read latency, byte-enabled writes
    logic [31:0] ram_mem [0:2047];
    bit          ram_wrt [0:2047];
    always @(posedge CLK) begin : ram_model
        logic [31:0] w;
        if (bus.ram_rden)
            bus.ram_q <= ram_wrt[bus.ram_addr] ? ram_mem[bus.ram_addr] : init_pat(bus.ram_addr);
        if (bus.ram_wren) begin
            w = ram_wrt[bus.ram_addr] ? ram_mem[bus.ram_addr] : init_pat(bus.ram_addr);
            for (int b = 0; b < 4; b++)
                if (bus.ram_be[b]) w[b*8 +: 8] = bus.ram_data[b*8 +: 8];
            ram_mem[bus.ram_addr] <= w;
            ram_wrt[bus.ram_addr] <= 1'b1;
        end
    end

    // monitor: compares port-B ops and read returns against the scoreboard
    bit          rv_due = 1'b0;
    logic [31:0] rv_dat = '0;
    always @(negedge CLK) begin : monitor
        op_t e;
        if (!RESET || !armed) begin
            rv_due = 1'b0;
        end else begin
            chk("disp_rvalid", bus.disp_rvalid, rv_due);
            if (rv_due) chk("disp_rdata", bus.disp_rdata, rv_dat);
            rv_due = 1'b0;
            if (exq.size() > 0 && exq[0].cyc == cyc - 1) begin
                e = exq.pop_front();
                if (e.kind == 1) begin
                    chk("ram_rd", {bus.ram_wren, bus.ram_rden, bus.ram_addr, bus.ram_be},
                                  {1'b0, 1'b1, e.addr, 4'hF});
                    rv_due = 1'b1;
                    rv_dat = e.data;
                end else if (e.kind == 2) begin
                    chk("ram_wr", {bus.ram_wren, bus.ram_rden, bus.ram_addr, bus.ram_be, bus.ram_data},
                                  {1'b1, 1'b0, e.addr, e.be, e.data});
                end else begin
                    chk("ram_idle", {bus.ram_wren, bus.ram_rden}, 2'b00);
                end
            end else begin
                chk("ram_idle", {bus.ram_wren, bus.ram_rden}, 2'b00);
            end
            if (bus.ram_wren) n_wren++;
        end
    end

    // one cycle of arbitration decided from the rules: display, forced writer, fair writer, clear, idle
    task automatic model_step(output logic [1:0] er);
        op_t         e;
        bit          forced, wg;
        int          k, p0;
        logic [10:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        er = 2'b00;
        wg = 1'b0;
        p0 = m_phase;
        forced = (m_stall == MAX_STALL) && bus.disp_req && (bus.wr_valid != 2'b00);
        e.cyc = cyc; e.kind = 0; e.addr = '0; e.data = '0; e.be = '0;
        if (bus.disp_req && !forced) begin
            e.kind = 1; e.addr = bus.disp_addr; e.be = 4'hF; e.data = m_mem[bus.disp_addr];
        end else if (bus.wr_valid != 2'b00) begin
            if (bus.wr_valid == 2'b11) k = (m_last == 0) ? 1 : 0;
            else                       k = bus.wr_valid[1] ? 1 : 0;
            er[k] = 1'b1;
            a = (k == 1) ? bus.wr_addr[21:11] : bus.wr_addr[10:0];
            d = (k == 1) ? bus.wr_data[63:32] : bus.wr_data[31:0];
            b = (k == 1) ? bus.wr_be[7:4]     : bus.wr_be[3:0];
            for (int i = 0; i < 4; i++)
                if (b[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
            e.kind = 2; e.addr = a; e.data = d; e.be = b;
            m_last = k;
            wg = 1'b1;
        end else if (p0 == 1) begin
            e.kind = 2; e.addr = 11'(m_caddr); e.data = 32'h0; e.be = 4'hF;
            m_mem[m_caddr] = 32'h0;
            if (m_caddr == CLEAR_LAST) m_phase = 2;
            else                       m_caddr++;
        end
        exq.push_back(e);
        if (p0 == 0 && bus.clr_start) begin
            m_phase = 1;
            m_caddr = 0;
        end else if (p0 == 2) begin
            m_phase = 0;
        end
        if (wg)                                              m_stall = 0;
        else if (bus.disp_req && bus.wr_valid != 2'b00)      m_stall = m_stall + 1;
        else                                                 m_stall = 0;
        if (forced)            m_miss = 1'b1;
        else if (bus.miss_clr) m_miss = 1'b0;
    endtask

    task automatic tick(input bit dreq, input logic [10:0] da, input logic [1:0] wv,
                        input bit cs, input bit mc);
        logic [1:0] er;
        @(posedge CLK); #1;
        RESET = 1'b1;
        chk("clr_busy",  bus.clr_busy,  m_phase == 1);
        chk("clr_done",  bus.clr_done,  m_phase == 2);
        chk("disp_miss", bus.disp_miss, m_miss);
        if (bus.clr_done) n_done++;
        bus.disp_req  = dreq;
        bus.disp_addr = da;
        bus.wr_valid  = wv;
        bus.wr_addr   = {11'($urandom_range(0, 63)), 11'($urandom_range(0, 63))};
        bus.wr_data   = {$urandom, $urandom};
        bus.wr_be     = 8'($urandom);
        bus.clr_start = cs;
        bus.miss_clr  = mc;
        model_step(er);
        @(negedge CLK);
        chk("wr_ready", bus.wr_ready, er);
        n_rdy0 += int'(bus.wr_ready[0]);
        n_rdy1 += int'(bus.wr_ready[1]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 11'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b0;
        bus.disp_req = 1'b0; bus.wr_valid = 2'b11; bus.clr_start = 1'b0; bus.miss_clr = 1'b0;
        exq.delete();
        m_stall = 0; m_last = 1; m_phase = 0; m_caddr = 0; m_miss = 1'b0;
        #1;
        armed = 1'b1;
        chk("rst_ram", {bus.ram_addr, bus.ram_data, bus.ram_be, bus.ram_wren, bus.ram_rden}, 64'h0);
        chk("rst_rvalid", bus.disp_rvalid, 1'b0);
        chk("rst_miss", bus.disp_miss, 1'b0);
        chk("rst_clr", {bus.clr_busy, bus.clr_done}, 2'b00);
        chk("rst_wr_ready", bus.wr_ready, 2'b00);
        bus.wr_valid = 2'b00;
        @(posedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  s0, s1, sw, sd;
        bit  seen;
        for (int i = 0; i < 2048; i++) m_mem[i] = init_pat(11'(i));
        bus.disp_req = 1'b0; bus.disp_addr = '0; bus.wr_valid = 2'b00; bus.wr_addr = '0;
        bus.wr_data = '0; bus.wr_be = '0; bus.clr_start = 1'b0; bus.miss_clr = 1'b0;
        #5;
        do_reset();

        // single display fetch of word 0x010
        tick(1'b1, 11'h010, 2'b00, 1'b0, 1'b0);
        idle(3);

        // two contending writers alternate starting with writer 0, then a lone writer streams
        s0 = n_rdy0; s1 = n_rdy1;
        for (int i = 0; i < 10; i++) tick(1'b0, 11'h0, 2'b11, 1'b0, 1'b0);
        chk("contend_w0", n_rdy0 - s0, 5);
        chk("contend_w1", n_rdy1 - s1, 5);
        s1 = n_rdy1;
        for (int i = 0; i < 6; i++) tick(1'b0, 11'h0, 2'b10, 1'b0, 1'b0);
        chk("lone_writer", n_rdy1 - s1, 6);
        idle(2);

        // display held against writer 0: writer forced through every 5th cycle
        s0 = n_rdy0;
        for (int i = 0; i < 25; i++) tick(1'b1, 11'($urandom_range(0, 63)), 2'b01, 1'b0, 1'b0);
        chk("starve_grants", n_rdy0 - s0, 5);
        idle(1);
        chk("starve_miss", bus.disp_miss, 1'b1);
        tick(1'b0, 11'h0, 2'b00, 1'b0, 1'b1);
        idle(1);
        chk("miss_cleared", bus.disp_miss, 1'b0);

        // full clear sweep with a display burst in the middle
        sw = n_wren; sd = n_done; seen = 1'b0;
        tick(1'b0, 11'h0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 900; i++) begin
            tick((i >= 50 && i < 60), 11'(i), 2'b00, 1'b0, 1'b0);
            if (n_done - sd == 1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("clr_finished", seen, 1'b1);
        idle(3);
        chk("clr_writes", n_wren - sw, CLEAR_LAST + 1);
        chk("clr_done_pulses", n_done - sd, 1);

        // reset part-way through a sweep with a read in flight
        seen = 1'b0;
        tick(1'b0, 11'h0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (m_caddr >= 300) begin
                seen = 1'b1;
                break;
            end
            tick(1'b0, 11'h0, 2'b00, 1'b0, 1'b0);
        end
        chk("sweep_reached_300", seen, 1'b1);
        tick(1'b1, 11'h005, 2'b00, 1'b0, 1'b0);
        sd = n_done;
        do_reset();
        idle(20);
        chk("abort_no_done", n_done - sd, 0);
        chk("abort_busy", bus.clr_busy, 1'b0);

        // randomized traffic in alternating light / display-heavy segments
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                tick($urandom_range(0, 9) < ((seg % 2) ? 9 : 5),
                     11'($urandom_range(0, 63)),
                     {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)},
                     ($urandom_range(0, 299) == 0),
                     ($urandom_range(0, 15) == 0));
            end
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_W, 11, VRAM word-address width.
- DATA_W, 32, VRAM word width.
- MAX_STALL, 4, consecutive display-blocked cycles before a writer is forced through.
- CLEAR_LAST, 599, last word address swept by the clear engine.
- CLEAR_WORD, 32'h0000_0000, data written by the clear engine.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, the single clock (50 MHz).
- RESET, in, 1, asynchronous active-low reset.
- disp_req, in, 1, display fetch request this cycle.
- disp_addr, in, ADDR_W, display fetch word address.
- disp_rdata, out, DATA_W, fetched word.
- disp_rvalid, out, 1, disp_rdata valid this cycle.
- wr_valid, in, 2, per-writer write request.
- wr_addr, in, 2*ADDR_W, writer k address in bits [k*ADDR_W +: ADDR_W].
- wr_data, in, 2*DATA_W, writer k data, same packing.
- wr_be, in, 8, writer k byte enables in bits [k*4 +: 4].
- wr_ready, out, 2, writer k granted this cycle.
- clr_start, in, 1, start a VRAM clear sweep.
- clr_busy, out, 1, sweep in progress.
- clr_done, out, 1, one-cycle pulse at sweep end.
- ram_addr, out, ADDR_W, RAM port B address.
- ram_data, out, DATA_W, RAM port B write data.
- ram_be, out, 4, RAM port B byte enables.
- ram_wren, out, 1, RAM port B write enable.
- ram_rden, out, 1, RAM port B read enable.
- ram_q, in, DATA_W, RAM port B read data (registered RAM, 1-cycle latency).
- disp_miss, out, 1, sticky flag: a display fetch was dropped.
- miss_clr, in, 1, clears disp_miss.

Function
REQ-003 The block SHALL decide exactly one grant per cycle, combinationally, in priority order: display; forced writer; round-robin writer; clear engine; idle.
REQ-004 Display SHALL be granted whenever disp_req=1, except in a forced cycle.
REQ-005 Writer k SHALL see a transfer only when wr_valid[k]=1 and wr_ready[k]=1 in the same cycle; wr_ready SHALL never be 1 without the matching wr_valid, and at most one wr_ready bit SHALL be high per cycle.
REQ-006 When both writers are valid and eligible, the writer not granted most recently SHALL win; the round-robin pointer SHALL update only on a writer grant.
REQ-007 A 3-bit stall counter SHALL increment each cycle in which disp_req=1 and wr_valid!=0, and SHALL clear on any writer grant or any cycle without that condition.
REQ-008 When the stall counter equals MAX_STALL, that cycle SHALL be a forced cycle: the round-robin writer is granted, the display request is dropped, and disp_miss is set.
REQ-009 disp_miss SHALL stay set until miss_clr=1; if a set and a clear occur in the same cycle, set SHALL win.
REQ-010 The granted request's address, data and byte enables SHALL be registered onto ram_* at the clock edge ending the grant cycle (one-cycle pipeline).
REQ-011 Display grants SHALL drive ram_rden=1 and ram_wren=0; writer and clear grants SHALL drive ram_wren=1 and ram_rden=0; idle cycles SHALL drive both to 0.
REQ-012 Display grants SHALL drive ram_be=4'hF; clear grants SHALL drive ram_be=4'hF.
REQ-013 disp_rdata SHALL equal ram_q.
REQ-014 disp_rvalid SHALL be 1 exactly two cycles after a granted display request (via a 2-stage valid pipe); dropped requests SHALL produce no rvalid.
REQ-015 The clear FSM SHALL have states IDLE, CLEAR and DONE.
- IDLE -> CLEAR on clr_start, with the clear address set to 0.
- In CLEAR, each clear grant writes CLEAR_WORD to the clear address, then increments it.
- The grant that writes CLEAR_LAST moves the FSM to DONE.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 clr_busy SHALL be 1 in CLEAR; clr_done SHALL be 1 only in DONE; clr_start SHALL be ignored outside IDLE.
REQ-017 The clear address SHALL hold, not skip, on cycles where a higher-priority requester wins.

Reset
REQ-018 While RESET=0, the block SHALL asynchronously force:
- ram_addr=0, ram_data=0, ram_be=0, ram_wren=0, ram_rden=0;
- disp_rvalid=0 and the valid pipe cleared;
- disp_miss=0;
- stall counter=0;
- round-robin pointer favouring writer 0;
- FSM=IDLE, clear address=0, clr_busy=0, clr_done=0.
wr_ready SHALL be 0 while RESET=0.
REQ-019 Reset asserted mid-sweep SHALL abort the sweep with no clr_done pulse; in-flight rvalids SHALL be discarded.

Verification
REQ-020 Display only: disp_req=1, addr=0x010 at cycle t -> ram_addr=0x010 and ram_rden=1 at t+1; disp_rvalid=1 with disp_rdata=RAM word 0x010 at t+2.
REQ-021 Contention: wr_valid=2'b11 held, disp_req=0 -> wr_ready alternates 01, 10, 01, ...; a single writer transfers every cycle.
REQ-022 Starvation: disp_req=1 held, wr_valid=2'b01 held, MAX_STALL=4 -> wr_ready[0]=1 on every 5th cycle; disp_miss=1 from the first forced cycle; no rvalid for dropped cycles; miss_clr=1 -> disp_miss=0.
REQ-023 Clear: clr_start pulse with no other traffic -> 600 consecutive writes of 0 to addresses 0..599, clr_busy=1 throughout, clr_done pulses once; a display burst mid-sweep leaves no address skipped.
REQ-024 Reset mid-sweep: RESET=0 at address 300 -> all outputs reach reset values immediately; after release, clr_busy=0 and no clr_done pulse.
